la_capture: RTL
===============

# la_capture

Parametrised single-port capture engine for the logic analyser: samples a `W`-bit input bus at a programmable rate into a `DEPTH`-entry ring buffer and holds a configurable pre-trigger history. It triggers on a masked pattern (level or edge) and streams the captured window out over a valid/ready interface. One instance per analyser port replaces the fixed 8-bit channel; the UART transfer mux consumes `o_data`/`o_valid`.

## Interface

**Parameters**
- `W`, 8: sample width in bits, 1–32.
- `DEPTH`, 256: buffer entries, power of two, ≥4; `AW = $clog2(DEPTH)`.
- `PW`, 16: prescaler width.

**Ports**
- `i_clk`, in, 1: sole clock.
- `_rst`, in, 1: asynchronous, active-low reset.
- `i_data`, in, W: probed bus, already synchronised upstream.
- `i_arm`, in, 1: start-capture pulse; ignored unless IDLE.
- `i_abort`, in, 1: return to IDLE from any state.
- `i_trig_mask`, in, W: 1 = bit participates in match.
- `i_trig_value`, in, W: required value of masked bits.
- `i_trig_edge`, in, 1: 0 = level match, 1 = rising match.
- `i_prescaler`, in, PW: sample every `i_prescaler+1` clocks.
- `i_pre_count`, in, AW+1: samples kept before the trigger.
- `i_post_count`, in, AW+1: samples from the trigger onward, trigger sample included.
- `o_data`, out, W: readout sample.
- `o_valid`, out, 1: `o_data` valid.
- `i_ready`, in, 1: consumer accepts.
- `o_last`, out, 1: final sample of the window.
- `o_running`, out, 1: state is PRE_FILL, WAIT_TRIG or POST.
- `o_triggered`, out, 1: trigger seen in the current capture.

## Operation

- **Config latch.** All config inputs are latched on an accepted `i_arm`. Clamping is applied at latch:
  - pre ≥ DEPTH → DEPTH−1.
  - post = 0 → 1.
  - post > DEPTH−pre → DEPTH−pre.
- **Sample tick.** The prescaler counter loads 0 on arm, so the first tick occurs in the first cycle after arm. Each tick writes `i_data` at `wr_ptr` and increments `wr_ptr` mod DEPTH.
- **Match.** `match = ((i_data ^ i_trig_value) & i_trig_mask) == 0`. In edge mode the trigger is `match & !match_prev`. `match_prev` updates on every tick from PRE_FILL onward and is set to 1 on arm, so a pattern already present at arm does not fire. A mask of 0 in level mode triggers on the first WAIT_TRIG tick.
- **States:**
  - IDLE → PRE_FILL on `i_arm`. If pre = 0, go straight to WAIT_TRIG.
  - PRE_FILL: write pre samples; the trigger is ignored; then → WAIT_TRIG.
  - WAIT_TRIG: keep writing (ring overwrite allowed). A trigger tick records `trig_ptr = wr_ptr` and writes that sample. Then → POST, or → READOUT directly if post = 1.
  - POST: write until post samples have been written since the trigger, then → READOUT.
  - READOUT: the read pointer starts at `(trig_ptr − pre) mod DEPTH` and emits pre+post samples. After the last handshake → IDLE.
- **Handshake.** A transfer occurs when `o_valid & i_ready`. While `o_valid & !i_ready`, `o_data`/`o_last` hold stable. Output uses a one-entry skid so throughput is 1 sample/clock when `i_ready` stays high.
- `i_abort` has priority over `i_arm` and over the trigger. It clears `o_valid`, `o_triggered` and `o_running` next cycle.
- **Reset values:** all outputs 0, state IDLE, pointers 0.

## Timing

- `i_arm` at cycle 0 → `o_running` = 1 at cycle 1; first sample written at cycle 1.
- Trigger tick at cycle t → `o_triggered` = 1 at t+1.
- Final POST write at cycle t → first `o_valid` at t+2 (state change, then synchronous RAM read).
- Last handshake at cycle t → `o_valid` = 0 and state IDLE at t+1; a new `i_arm` is accepted at t+1.
- Abort at cycle t → IDLE at t+1.
- Async reset mid-capture → IDLE immediately; the buffer contents are undefined and never emitted.

## Configuration

- `LA_CAPTURE_EXT_TRIG_EN` defined:
  - Adds port `i_ext_trig`, in, 1.
  - `i_ext_trig` is sampled on ticks; the trigger becomes pattern-trigger OR a rising edge of `i_ext_trig` between consecutive ticks.
  - The ext-trig previous-sample register is cleared on arm.
- Undefined: port absent; only the pattern trigger is used.

## Structure

- Package `la_pkg`: state enum (IDLE, PRE_FILL, WAIT_TRIG, POST, READOUT) and the config clamp function.
- Sub-module `la_ring_ram`: DEPTH×W simple dual-port RAM, synchronous write and synchronous read, one-cycle read latency.

## Test plan

All scenarios use W=8, DEPTH=16.

- **Basic window:** pre=4, post=4, prescaler=0, mask=FF, value=0x10, level mode, `i_data` = counter from 0x00 → emits 0x0C..0x13, `o_last` on 0x13, `o_triggered` the cycle after 0x10 is sampled.
- **Clamping and prescaler:** pre=20, post=20 → clamped to pre=15, post=1; exactly 16 samples emitted. Prescaler=3 → `i_data` is sampled every 4th clock.
- **Edge mode:** `i_data` held at 0x10 from before arm, edge mode → no trigger. Data goes to 0x11 and back to 0x10 → trigger fires on the return to 0x10.
- **Backpressure:** `i_ready` toggled 1,0,0,1,… during readout → `o_data` stable while stalled; no sample lost or duplicated; count matches pre+post.
- **Abort and reset:** abort in WAIT_TRIG, and async reset in READOUT → next cycle IDLE with all outputs 0; re-arm completes a normal capture.
- **Ext trigger (`LA_CAPTURE_EXT_TRIG_EN`):** mask=00, edge mode, `i_ext_trig` pulsed → the capture triggers on the tick following the rising edge.

Source files
------------

// File: rtl/la_pkg.sv
// la_pkg -- shared types and helpers for the la_capture logic-analyser engine.
//
// Contents:
//   la_state_e : capture state machine encoding
//                (IDLE, PRE_FILL, WAIT_TRIG, POST, READOUT)
//   la_cfg_t   : clamped pre/post sample counts
//   clamp_cfg  : folds the requested pre/post counts into a window that fits
//                the ring buffer
package la_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE_FILL,
      WAIT_TRIG,
      POST,
      READOUT
   } la_state_e;

   typedef struct packed {
      int pre;
      int post;
   } la_cfg_t;

   // The window must fit in the ring: at most DEPTH-1 history samples, at
   // least the trigger sample itself, and pre+post never above DEPTH.
   function automatic la_cfg_t clamp_cfg(input int pre, input int post, input int depth);
      la_cfg_t c;
      c.pre  = (pre >= depth) ? depth - 1 : pre;
      c.post = (post == 0) ? 1 : post;
      if (c.post > depth - c.pre) begin
         c.post = depth - c.pre;
      end
      return c;
   endfunction

endpackage

// File: rtl/la_ring_ram.sv
// la_ring_ram -- DEPTH x W simple dual-port RAM for the capture ring buffer.
//
// Ports:
//   clk   : clock
//   we    : write enable, writes wdata to mem[waddr]
//   waddr : write address
//   wdata : write data
//   re    : read enable, registers mem[raddr] into rdata (one-cycle latency)
//   raddr : read address
//   rdata : registered read data, holds while re is low
module la_ring_ram #(
   parameter int W = 8,
   parameter int DEPTH = 256,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/la_capture.sv
// la_capture -- logic-analyser capture engine for one probed bus.
//
// Samples i_data every i_prescaler+1 clocks into a DEPTH-entry ring, keeps a
// pre-trigger history, triggers on a masked level or rising pattern match and
// streams the captured window out over a valid/ready interface.
//
// Optional feature: define LA_CAPTURE_EXT_TRIG_EN to add i_ext_trig; a rising
// edge of it between consecutive sample ticks also triggers the capture.
//
// Ports:
//   i_clk, _rst            : clock, asynchronous active-low reset
//   i_data                 : probed bus
//   i_arm, i_abort         : start capture (IDLE only) / return to IDLE
//   i_trig_mask/value/edge : trigger pattern, 0 = level, 1 = rising match
//   i_prescaler            : sample every i_prescaler+1 clocks
//   i_pre_count/post_count : window size around the trigger
//   i_ext_trig             : external trigger (LA_CAPTURE_EXT_TRIG_EN only)
//   o_data/o_valid/o_last  : readout stream, i_ready accepts
//   o_running, o_triggered : status
module la_capture
   import la_pkg::*;
#(
   parameter int W = 8,
   parameter int DEPTH = 256,
   parameter int PW = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          _rst,
   input  logic [W-1:0]  i_data,
   input  logic          i_arm,
   input  logic          i_abort,
   input  logic [W-1:0]  i_trig_mask,
   input  logic [W-1:0]  i_trig_value,
   input  logic          i_trig_edge,
   input  logic [PW-1:0] i_prescaler,
   input  logic [AW:0]   i_pre_count,
   input  logic [AW:0]   i_post_count,
`ifdef LA_CAPTURE_EXT_TRIG_EN
   input  logic          i_ext_trig,
`endif
   output logic [W-1:0]  o_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic          o_last,
   output logic          o_running,
   output logic          o_triggered
);

   la_state_e     state, state_next;
   la_cfg_t       arm_cfg;

   // latched configuration
   logic [W-1:0]  mask, value;
   logic          edge_mode;
   logic [PW-1:0] presc;
   logic [AW:0]   pre_n, post_n;

   // capture side
   logic [PW-1:0] presc_cnt;
   logic [AW-1:0] wr_ptr, trig_ptr;
   logic [AW:0]   cnt, cnt_inc;
   logic          match, match_prev, pat_trig, ext_rise, trig;
   logic          running, tick, arm_accept, go_readout;

   // readout side
   logic [AW-1:0] rd_ptr, raddr, start_ptr;
   logic [AW:0]   remaining, rem_base;
   logic          issue, rd_pend, pend_last, pop;
   logic [1:0]    occ;
   logic [W-1:0]  ram_q, skid_data;
   logic          skid_valid, skid_last;

   assign arm_cfg    = clamp_cfg(int'(i_pre_count), int'(i_post_count), DEPTH);
   assign running    = (state == PRE_FILL) || (state == WAIT_TRIG) || (state == POST);
   assign tick       = running && (presc_cnt == '0);
   assign arm_accept = (state == IDLE) && i_arm && !i_abort;
   assign cnt_inc    = cnt + (AW+1)'(1);
   assign o_running  = running;

   assign match    = ((i_data ^ value) & mask) == '0;
   assign pat_trig = edge_mode ? (match && !match_prev) : match;
   assign trig     = pat_trig || ext_rise;

`ifdef LA_CAPTURE_EXT_TRIG_EN
   logic ext_prev;

   always_ff @(posedge i_clk or negedge _rst) begin
      if (!_rst) begin
         ext_prev <= 1'b0;
      end else if (arm_accept) begin
         ext_prev <= 1'b0;
      end else if (tick) begin
         ext_prev <= i_ext_trig;
      end
   end

   assign ext_rise = i_ext_trig && !ext_prev;
`else
   assign ext_rise = 1'b0;
`endif

   // next state
   always_comb begin
      state_next = state;
      go_readout = 1'b0;
      case (state)
         IDLE: begin
            if (i_arm) begin
               state_next = (arm_cfg.pre == 0) ? WAIT_TRIG : PRE_FILL;
            end
         end
         PRE_FILL: begin
            if (tick && (cnt_inc == pre_n)) begin
               state_next = WAIT_TRIG;
            end
         end
         WAIT_TRIG: begin
            if (tick && trig) begin
               if (post_n == (AW+1)'(1)) begin
                  state_next = READOUT;
                  go_readout = 1'b1;
               end else begin
                  state_next = POST;
               end
            end
         end
         POST: begin
            if (tick && (cnt_inc == post_n)) begin
               state_next = READOUT;
               go_readout = 1'b1;
            end
         end
         READOUT: begin
            if (o_valid && i_ready && o_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (i_abort) begin
         state_next = IDLE;
         go_readout = 1'b0;
      end
   end

   // The first read is issued in the cycle of the final write so the first
   // sample reaches o_data two cycles later. When the trigger itself ends the
   // capture, trig_ptr is not yet registered, so use wr_ptr directly.
   assign start_ptr = ((state == WAIT_TRIG) ? wr_ptr : trig_ptr) - pre_n[AW-1:0];
   assign raddr     = go_readout ? start_ptr : rd_ptr;
   assign rem_base  = go_readout ? (pre_n + post_n) : remaining;

   // Output register + skid + one read in flight never exceed two entries,
   // so a read is only issued when that budget has room after this cycle's pop.
   assign pop   = o_valid && i_ready;
   assign occ   = {1'b0, o_valid} + {1'b0, skid_valid} + {1'b0, rd_pend};
   assign issue = go_readout ||
                  ((state == READOUT) && !i_abort && (remaining != '0) &&
                   ((occ - {1'b0, pop}) < 2'd2));

   la_ring_ram #(.W(W), .DEPTH(DEPTH)) u_ram (
      .clk   (i_clk),
      .we    (tick),
      .waddr (wr_ptr),
      .wdata (i_data),
      .re    (issue),
      .raddr (raddr),
      .rdata (ram_q)
   );

   always_ff @(posedge i_clk or negedge _rst) begin
      if (!_rst) begin
         state       <= IDLE;
         mask        <= '0;
         value       <= '0;
         edge_mode   <= 1'b0;
         presc       <= '0;
         pre_n       <= '0;
         post_n      <= '0;
         presc_cnt   <= '0;
         wr_ptr      <= '0;
         trig_ptr    <= '0;
         rd_ptr      <= '0;
         cnt         <= '0;
         remaining   <= '0;
         match_prev  <= 1'b0;
         rd_pend     <= 1'b0;
         pend_last   <= 1'b0;
         skid_valid  <= 1'b0;
         skid_data   <= '0;
         skid_last   <= 1'b0;
         o_valid     <= 1'b0;
         o_data      <= '0;
         o_last      <= 1'b0;
         o_triggered <= 1'b0;
      end else if (i_abort) begin
         state       <= IDLE;
         remaining   <= '0;
         rd_pend     <= 1'b0;
         skid_valid  <= 1'b0;
         o_valid     <= 1'b0;
         o_data      <= '0;
         o_last      <= 1'b0;
         o_triggered <= 1'b0;
      end else begin
         state <= state_next;

         if (arm_accept) begin
            mask        <= i_trig_mask;
            value       <= i_trig_value;
            edge_mode   <= i_trig_edge;
            presc       <= i_prescaler;
            pre_n       <= (AW+1)'(arm_cfg.pre);
            post_n      <= (AW+1)'(arm_cfg.post);
            presc_cnt   <= '0;
            wr_ptr      <= '0;
            cnt         <= '0;
            // a pattern already present at arm must not look like an edge
            match_prev  <= 1'b1;
            o_triggered <= 1'b0;
         end

         if (tick) begin
            presc_cnt  <= presc;
            wr_ptr     <= wr_ptr + 1'b1;
            match_prev <= match;
            case (state)
               PRE_FILL: cnt <= cnt_inc;
               WAIT_TRIG: begin
                  if (trig) begin
                     cnt         <= (AW+1)'(1);
                     trig_ptr    <= wr_ptr;
                     o_triggered <= 1'b1;
                  end
               end
               POST:    cnt <= cnt_inc;
               default: ;
            endcase
         end else if (running) begin
            presc_cnt <= presc_cnt - 1'b1;
         end

         rd_pend <= issue;
         if (issue) begin
            rd_ptr    <= raddr + 1'b1;
            remaining <= rem_base - (AW+1)'(1);
            pend_last <= (rem_base == (AW+1)'(1));
         end

         // output register with one-entry skid
         if (o_valid && !i_ready) begin
            if (rd_pend) begin
               skid_valid <= 1'b1;
               skid_data  <= ram_q;
               skid_last  <= pend_last;
            end
         end else if (skid_valid) begin
            o_valid <= 1'b1;
            o_data  <= skid_data;
            o_last  <= skid_last;
            if (rd_pend) begin
               skid_data <= ram_q;
               skid_last <= pend_last;
            end else begin
               skid_valid <= 1'b0;
            end
         end else if (rd_pend) begin
            o_valid <= 1'b1;
            o_data  <= ram_q;
            o_last  <= pend_last;
         end else begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
         end
      end
   end

endmodule
